// File: rtl/spi_command_dispatcher.sv
// rtl/spi_command_dispatcher.sv - turns spi_reader bytes into sprite-RAM writes and a draw-entry FIFO
// Statistics counters are built only when SPI_DISPATCH_STATS_EN is defined.
module spi_command_dispatcher #(
   parameter int DRAW_FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        byte_read,
   input  logic [7:0]  command,
   input  logic [7:0]  data,
   input  logic [15:0] data_index,
   output logic        sprite_wr_en,
   output logic [7:0]  sprite_wr_id,
   output logic [8:0]  sprite_wr_addr,
   output logic [7:0]  sprite_wr_data,
   output logic        draw_valid,
   input  logic        draw_ready,
   output logic [7:0]  draw_sprite_id,
   output logic [15:0] draw_x,
   output logic [15:0] draw_y,
   output logic [7:0]  draw_depth,
   output logic        draw_overflow,
   output logic [15:0] stat_saved,
   output logic [15:0] stat_queued,
   output logic [15:0] stat_dropped
);
   localparam logic [7:0] COMMAND_SAVE_SPRITE = 8'h01;
   localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'h02;
   localparam int AW = $clog2(DRAW_FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DRAW_FIFO_DEPTH);

   logic        strobe_d;
   logic        is_save;
   logic        is_draw;
   logic [15:0] save_addr;
   logic [7:0]  save_id;
   logic [7:0]  arg_id;
   logic [15:0] arg_x;
   logic [15:0] arg_y;
   logic        push;
   logic [47:0] push_entry;

   logic [47:0] fifo_mem [DRAW_FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          pop;
   logic          accept;
   logic          drop;

   assign is_save   = (command == COMMAND_SAVE_SPRITE);
   assign is_draw   = (command == COMMAND_DRAW_SPRITE);
   assign save_addr = data_index - 16'd2;

   // Byte decode runs one cycle after byte_read, once the parser has updated command/index.
   always_ff @(posedge clock) begin
      if (reset) begin
         strobe_d       <= 1'b0;
         save_id        <= '0;
         arg_id         <= '0;
         arg_x          <= '0;
         arg_y          <= '0;
         push           <= 1'b0;
         push_entry     <= '0;
         sprite_wr_en   <= 1'b0;
         sprite_wr_id   <= '0;
         sprite_wr_addr <= '0;
         sprite_wr_data <= '0;
      end else begin
         strobe_d     <= byte_read;
         sprite_wr_en <= 1'b0;
         push         <= 1'b0;
         if (strobe_d) begin
            if (data_index == 16'd0) begin
               arg_id <= '0;
               arg_x  <= '0;
               arg_y  <= '0;
            end else if (is_save && data_index == 16'd1) begin
               save_id <= data;
            end else if (is_save && data_index <= 16'd513) begin
               sprite_wr_en   <= 1'b1;
               sprite_wr_id   <= save_id;
               sprite_wr_addr <= save_addr[8:0];
               sprite_wr_data <= data;
            end else if (is_draw && data_index <= 16'd6) begin
               case (data_index[2:0])
                  3'd1:    arg_id       <= data;
                  3'd2:    arg_x[15:8]  <= data;
                  3'd3:    arg_x[7:0]   <= data;
                  3'd4:    arg_y[15:8]  <= data;
                  3'd5:    arg_y[7:0]   <= data;
                  default: begin
                     push       <= 1'b1;
                     push_entry <= {arg_id, arg_x, arg_y, data};
                  end
               endcase
            end
         end
      end
   end

   assign full       = (count == FULL_COUNT);
   assign draw_valid = (count != '0);
   assign pop        = draw_valid && draw_ready;
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign accept     = push && (!full || pop);
   assign drop       = push && full && !pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         draw_overflow <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
            2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
            default: count <= count;
         endcase
         if (drop) draw_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (accept) fifo_mem[wr_ptr] <= push_entry;
   end

   assign {draw_sprite_id, draw_x, draw_y, draw_depth} = draw_valid ? fifo_mem[rd_ptr] : 48'd0;

`ifdef SPI_DISPATCH_STATS_EN
   logic [15:0] saved_q;
   logic [15:0] queued_q;
   logic [15:0] dropped_q;

   // The last pixel of a SAVE is the only write that lands on address 511.
   always_ff @(posedge clock) begin
      if (reset) begin
         saved_q   <= '0;
         queued_q  <= '0;
         dropped_q <= '0;
      end else begin
         if (sprite_wr_en && sprite_wr_addr == 9'd511 && saved_q != 16'hFFFF) saved_q <= saved_q + 16'd1;
         if (accept && queued_q != 16'hFFFF) queued_q <= queued_q + 16'd1;
         if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
      end
   end

   assign stat_saved   = saved_q;
   assign stat_queued  = queued_q;
   assign stat_dropped = dropped_q;
`else
   assign stat_saved   = '0;
   assign stat_queued  = '0;
   assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_spi_command_dispatcher.sv
// tb/tb_spi_command_dispatcher.sv - self-checking bench for spi_command_dispatcher
module tb_spi_command_dispatcher;
   localparam int DEPTH = 16;
   localparam logic [7:0] CMD_SAVE = 8'h01;
   localparam logic [7:0] CMD_DRAW = 8'h02;
`ifdef SPI_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic byte_read = 1'b0;
   logic draw_ready = 1'b0;
   logic [7:0] command = 8'd0;
   logic [7:0] data = 8'd0;
   logic [15:0] data_index = 16'd0;
   logic sprite_wr_en, draw_valid, draw_overflow;
   logic [7:0] sprite_wr_id, sprite_wr_data, draw_sprite_id, draw_depth;
   logic [8:0] sprite_wr_addr;
   logic [15:0] draw_x, draw_y, stat_saved, stat_queued, stat_dropped;

   spi_command_dispatcher #(.DRAW_FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .byte_read(byte_read), .command(command),
      .data(data), .data_index(data_index),
      .sprite_wr_en(sprite_wr_en), .sprite_wr_id(sprite_wr_id),
      .sprite_wr_addr(sprite_wr_addr), .sprite_wr_data(sprite_wr_data),
      .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_sprite_id(draw_sprite_id),
      .draw_x(draw_x), .draw_y(draw_y), .draw_depth(draw_depth),
      .draw_overflow(draw_overflow), .stat_saved(stat_saved),
      .stat_queued(stat_queued), .stat_dropped(stat_dropped)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0]  id;
      logic [8:0]  addr;
      logic [7:0]  data;
      logic [31:0] cyc;
   } wr_t;

   wr_t obs_wr[$];
   wr_t exp_wr[$];
   logic [47:0] obs_draw[$];
   logic [47:0] exp_draw[$];
   int cyc = 0;
   int last_br_cyc = 0;
   int valid_rise_cyc = -1;
   int n_checks = 0;
   int n_fail = 0;
   int stall_viol = 0;
   int cur_idx = 0;
   int model_occ = 0;
   int exp_saved = 0, exp_queued = 0, exp_dropped = 0;
   int extra_gap = 0;
   bit rand_ready = 1'b0;
   bit hold = 1'b0;
   bit prev_valid = 1'b0;
   bit prev_hold = 1'b0;
   logic [47:0] prev_head = '0;

   always @(posedge clock) cyc <= cyc + 1;

   // Passive observer: records write strobes and popped draw entries with their cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (sprite_wr_en) obs_wr.push_back('{id: sprite_wr_id, addr: sprite_wr_addr, data: sprite_wr_data, cyc: 32'(cyc)});
         if (draw_valid && draw_ready) obs_draw.push_back({draw_sprite_id, draw_x, draw_y, draw_depth});
         if (draw_valid && !prev_valid && valid_rise_cyc < 0) valid_rise_cyc = cyc;
         if (prev_hold && !(draw_valid && {draw_sprite_id, draw_x, draw_y, draw_depth} == prev_head)) stall_viol++;
      end
      prev_valid = draw_valid;
      prev_hold  = !reset && draw_valid && !draw_ready;
      prev_head  = {draw_sprite_id, draw_x, draw_y, draw_depth};
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_ready) draw_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit pop_with_push);
      tick();
      byte_read = 1'b1;
      data = b;
      last_br_cyc = cyc;
      tick();
      byte_read = 1'b0;
      data_index = 16'(cur_idx);
      if (cur_idx == 0) command = b;
      tick();
      if (pop_with_push) draw_ready = 1'b1;
      tick();
      if (pop_with_push) draw_ready = 1'b0;
      if (extra_gap > 0) repeat ($urandom_range(0, extra_gap)) tick();
      cur_idx++;
   endtask

   task automatic send_save(input logic [7:0] id, input int nbytes, input bit rnd);
      logic [7:0] v;
      cur_idx = 0;
      send_byte(CMD_SAVE, 1'b0);
      send_byte(id, 1'b0);
      for (int i = 0; i < nbytes; i++) begin
         v = rnd ? 8'($urandom) : 8'(i);
         send_byte(v, 1'b0);
         exp_wr.push_back('{id: id, addr: 9'(i), data: v, cyc: 32'(last_br_cyc + 2)});
      end
      if (nbytes == 512) exp_saved++;
   endtask

   task automatic send_draw(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                            input logic [7:0] dep, input int nargs, input bit pop_with_push);
      logic [7:0] args [6];
      args = '{id, x[15:8], x[7:0], y[15:8], y[7:0], dep};
      cur_idx = 0;
      send_byte(CMD_DRAW, 1'b0);
      for (int i = 0; i < nargs; i++) send_byte(args[i], pop_with_push && i == 5);
      if (nargs == 6) begin
         if (hold && model_occ >= DEPTH && !pop_with_push) exp_dropped++;
         else begin
            exp_draw.push_back({id, x, y, dep});
            exp_queued++;
            if (hold && !pop_with_push) model_occ++;
         end
      end
   endtask

   task automatic send_unknown(input logic [7:0] cmd, input int n);
      cur_idx = 0;
      send_byte(cmd, 1'b0);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), 1'b0);
   endtask

   task automatic send_random_draw(input int nargs);
      send_draw(8'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), nargs, 1'b0);
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      draw_ready = 1'b1;
      repeat (2 * DEPTH + 8) tick();
      draw_ready = 1'b0;
      model_occ = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      byte_read = 1'b0;
      draw_ready = 1'b0;
      rand_ready = 1'b0;
      hold = 1'b0;
      extra_gap = 0;
      command = 8'd0;
      data = 8'd0;
      data_index = 16'd0;
      repeat (2) tick();
      reset = 1'b0;
      obs_wr.delete(); exp_wr.delete(); obs_draw.delete(); exp_draw.delete();
      model_occ = 0; exp_saved = 0; exp_queued = 0; exp_dropped = 0;
      valid_rise_cyc = -1;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      byte_read = 1'b1;
      command = CMD_SAVE;
      data = 8'hA5;
      data_index = 16'd5;
      repeat (2) tick();
      @(negedge clock);
      n_checks++;
      if ({sprite_wr_en, sprite_wr_id, sprite_wr_addr, sprite_wr_data} !== 26'd0) begin
         n_fail++; $display("FAIL reset_sprite: got %h expected 0", {sprite_wr_en, sprite_wr_id, sprite_wr_addr, sprite_wr_data});
      end
      n_checks++;
      if ({draw_valid, draw_sprite_id, draw_x, draw_y, draw_depth} !== 49'd0) begin
         n_fail++; $display("FAIL reset_draw: got %h expected 0", {draw_valid, draw_sprite_id, draw_x, draw_y, draw_depth});
      end
      n_checks++;
      if ({draw_overflow, stat_saved, stat_queued, stat_dropped} !== 49'd0) begin
         n_fail++; $display("FAIL reset_stats: got %h expected 0", {draw_overflow, stat_saved, stat_queued, stat_dropped});
      end
      byte_read = 1'b0;
      reset = 1'b0;
      obs_wr.delete();
      repeat (6) tick();
      n_checks++;
      if (obs_wr.size() != 0) begin
         n_fail++; $display("FAIL reset_pending_strobe: got %0d writes expected 0", obs_wr.size());
      end
   endtask

   task automatic test_save();
      do_reset();
      send_save(8'h05, 512, 1'b0);
      repeat (4) tick();
      n_checks++;
      if (obs_wr.size() != 512) begin
         n_fail++; $display("FAIL save_count: got %0d expected 512", obs_wr.size());
      end
      for (int i = 0; i < 512 && i < obs_wr.size(); i++) begin
         n_checks++;
         if (obs_wr[i] !== exp_wr[i]) begin
            n_fail++; $display("FAIL save_write[%0d]: got id %h addr %0d data %h cyc %0d expected id %h addr %0d data %h cyc %0d",
                               i, obs_wr[i].id, obs_wr[i].addr, obs_wr[i].data, obs_wr[i].cyc,
                               exp_wr[i].id, exp_wr[i].addr, exp_wr[i].data, exp_wr[i].cyc);
         end
      end
      n_checks++;
      if (stat_saved !== (STATS ? 16'(exp_saved) : 16'd0)) begin
         n_fail++; $display("FAIL save_stat: got %0d expected %0d", stat_saved, STATS ? exp_saved : 0);
      end
      n_checks++;
      if ({sprite_wr_en, sprite_wr_id, sprite_wr_addr, sprite_wr_data} !== {1'b0, 8'h05, 9'd511, 8'hFF}) begin
         n_fail++; $display("FAIL save_hold: got %h expected %h", {sprite_wr_en, sprite_wr_id, sprite_wr_addr, sprite_wr_data}, {1'b0, 8'h05, 9'd511, 8'hFF});
      end
   endtask

   task automatic test_draw_single();
      do_reset();
      draw_ready = 1'b1;
      send_draw(8'h03, 16'h0120, 16'h0040, 8'h07, 6, 1'b0);
      repeat (4) tick();
      n_checks++;
      if (obs_draw.size() != 1) begin
         n_fail++; $display("FAIL draw_single_count: got %0d expected 1", obs_draw.size());
      end else begin
         n_checks++;
         if (obs_draw[0] !== 48'h03_0120_0040_07) begin
            n_fail++; $display("FAIL draw_single_entry: got %h expected %h", obs_draw[0], 48'h03_0120_0040_07);
         end
      end
      n_checks++;
      if (valid_rise_cyc != last_br_cyc + 3) begin
         n_fail++; $display("FAIL draw_single_latency: got %0d expected %0d", valid_rise_cyc - last_br_cyc, 3);
      end
      n_checks++;
      if (obs_wr.size() != 0) begin
         n_fail++; $display("FAIL draw_single_nowrite: got %0d writes expected 0", obs_wr.size());
      end
      n_checks++;
      if (stat_queued !== (STATS ? 16'd1 : 16'd0)) begin
         n_fail++; $display("FAIL draw_single_stat: got %0d expected %0d", stat_queued, STATS ? 1 : 0);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      hold = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) send_random_draw(6);
      tick();
      n_checks++;
      if (draw_overflow !== 1'b1) begin
         n_fail++; $display("FAIL overflow_flag: got %b expected 1", draw_overflow);
      end
      n_checks++;
      if ({stat_queued, stat_dropped} !== (STATS ? {16'(exp_queued), 16'(exp_dropped)} : 32'd0)) begin
         n_fail++; $display("FAIL overflow_stats: got %0d/%0d expected %0d/%0d", stat_queued, stat_dropped,
                            STATS ? exp_queued : 0, STATS ? exp_dropped : 0);
      end
      n_checks++;
      if (!draw_valid || {draw_sprite_id, draw_x, draw_y, draw_depth} !== exp_draw[0]) begin
         n_fail++; $display("FAIL overflow_head: got %b/%h expected 1/%h", draw_valid, {draw_sprite_id, draw_x, draw_y, draw_depth}, exp_draw[0]);
      end
      drain();
      n_checks++;
      if (obs_draw.size() != DEPTH) begin
         n_fail++; $display("FAIL overflow_drain_count: got %0d expected %0d", obs_draw.size(), DEPTH);
      end
      for (int i = 0; i < DEPTH && i < obs_draw.size(); i++) begin
         n_checks++;
         if (obs_draw[i] !== exp_draw[i]) begin
            n_fail++; $display("FAIL overflow_entry[%0d]: got %h expected %h", i, obs_draw[i], exp_draw[i]);
         end
      end
      n_checks++;
      if ({draw_valid, draw_overflow} !== 2'b01) begin
         n_fail++; $display("FAIL overflow_after_drain: got %b expected 01", {draw_valid, draw_overflow});
      end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) send_random_draw(6);
      send_draw(8'hC3, 16'hBEEF, 16'h1234, 8'h5A, 6, 1'b1);
      tick();
      n_checks++;
      if (draw_overflow !== 1'b0) begin
         n_fail++; $display("FAIL fullpp_overflow: got %b expected 0", draw_overflow);
      end
      n_checks++;
      if ({stat_queued, stat_dropped} !== (STATS ? {16'(DEPTH + 1), 16'd0} : 32'd0)) begin
         n_fail++; $display("FAIL fullpp_stats: got %0d/%0d expected %0d/0", stat_queued, stat_dropped, STATS ? DEPTH + 1 : 0);
      end
      drain();
      n_checks++;
      if (obs_draw.size() != DEPTH + 1) begin
         n_fail++; $display("FAIL fullpp_count: got %0d expected %0d", obs_draw.size(), DEPTH + 1);
      end
      for (int i = 0; i < exp_draw.size() && i < obs_draw.size(); i++) begin
         n_checks++;
         if (obs_draw[i] !== exp_draw[i]) begin
            n_fail++; $display("FAIL fullpp_entry[%0d]: got %h expected %h", i, obs_draw[i], exp_draw[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      hold = 1'b1;
      send_random_draw(6);
      send_random_draw(6);
      send_draw(8'h11, 16'h2222, 16'h3333, 8'h44, 3, 1'b0);
      tick();
      byte_read = 1'b1;
      data = 8'h33;
      tick();
      byte_read = 1'b0;
      data_index = 16'd4;
      reset = 1'b1;
      tick();
      @(negedge clock);
      n_checks++;
      if ({sprite_wr_en, sprite_wr_id, sprite_wr_addr, sprite_wr_data, draw_valid, draw_sprite_id, draw_x, draw_y, draw_depth} !== 75'd0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got %h expected 0",
                            {sprite_wr_en, sprite_wr_id, sprite_wr_addr, sprite_wr_data, draw_valid, draw_sprite_id, draw_x, draw_y, draw_depth});
      end
      n_checks++;
      if ({draw_overflow, stat_saved, stat_queued, stat_dropped} !== 49'd0) begin
         n_fail++; $display("FAIL reset_mid_stats: got %h expected 0", {draw_overflow, stat_saved, stat_queued, stat_dropped});
      end
      tick();
      reset = 1'b0;
      hold = 1'b0;
      obs_draw.delete(); exp_draw.delete(); obs_wr.delete();
      model_occ = 0; exp_queued = 0;
      draw_ready = 1'b1;
      send_draw(8'h66, 16'h0777, 16'h0888, 8'h99, 6, 1'b0);
      repeat (4) tick();
      n_checks++;
      if (obs_draw.size() != 1) begin
         n_fail++; $display("FAIL reset_mid_count: got %0d expected 1", obs_draw.size());
      end else begin
         n_checks++;
         if (obs_draw[0] !== 48'h66_0777_0888_99) begin
            n_fail++; $display("FAIL reset_mid_entry: got %h expected %h", obs_draw[0], 48'h66_0777_0888_99);
         end
      end
   endtask

   task automatic test_unknown();
      do_reset();
      draw_ready = 1'b1;
      send_unknown(8'hEE, 8);
      send_draw(8'h21, 16'hFEDC, 16'h0102, 8'h80, 6, 1'b0);
      repeat (4) tick();
      n_checks++;
      if (obs_wr.size() != 0) begin
         n_fail++; $display("FAIL unknown_nowrite: got %0d writes expected 0", obs_wr.size());
      end
      n_checks++;
      if (obs_draw.size() != 1 || obs_draw[0] !== 48'h21_FEDC_0102_80) begin
         n_fail++; $display("FAIL unknown_draw: got %0d entries head %h expected 1 entry %h",
                            obs_draw.size(), obs_draw.size() > 0 ? obs_draw[0] : 48'd0, 48'h21_FEDC_0102_80);
      end
   endtask

   task automatic test_random();
      int full_draws = 0;
      do_reset();
      rand_ready = 1'b1;
      extra_gap = 2;
      for (int p = 0; p < 40; p++) begin
         case ($urandom_range(0, 3))
            0: send_save(8'($urandom), $urandom_range(0, 12), 1'b1);
            1: begin
               if (full_draws < 10) begin send_random_draw(6); full_draws++; end
               else send_random_draw($urandom_range(0, 5));
            end
            2: send_random_draw($urandom_range(0, 5));
            default: send_unknown(8'($urandom_range(3, 255)), $urandom_range(0, 8));
         endcase
      end
      drain();
      n_checks++;
      if (obs_wr.size() != exp_wr.size()) begin
         n_fail++; $display("FAIL random_write_count: got %0d expected %0d", obs_wr.size(), exp_wr.size());
      end
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
         n_checks++;
         if (obs_wr[i] !== exp_wr[i]) begin
            n_fail++; $display("FAIL random_write[%0d]: got %h expected %h", i, obs_wr[i], exp_wr[i]);
         end
      end
      n_checks++;
      if (obs_draw.size() != exp_draw.size()) begin
         n_fail++; $display("FAIL random_draw_count: got %0d expected %0d", obs_draw.size(), exp_draw.size());
      end
      for (int i = 0; i < exp_draw.size() && i < obs_draw.size(); i++) begin
         n_checks++;
         if (obs_draw[i] !== exp_draw[i]) begin
            n_fail++; $display("FAIL random_draw[%0d]: got %h expected %h", i, obs_draw[i], exp_draw[i]);
         end
      end
      n_checks++;
      if (stat_queued !== (STATS ? 16'(exp_queued) : 16'd0) || draw_overflow !== 1'b0) begin
         n_fail++; $display("FAIL random_stats: got queued %0d overflow %b expected %0d 0", stat_queued, draw_overflow, STATS ? exp_queued : 0);
      end
      n_checks++;
      if (stall_viol != 0) begin
         n_fail++; $display("FAIL head_stable: got %0d violations expected 0", stall_viol);
      end
   endtask

   initial begin
      test_reset();
      test_save();
      test_draw_single();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_unknown();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
